sine_dds: RTL and testbench

- Parametrised direct-digital-synthesis sine generator built around a quarter-wave magnitude LUT.
- A phase accumulator drives quadrant decode, mirrored LUT addressing and sign restoration to produce a full-wave signed sine.
- The output uses a valid/ready stream with backpressure.
- Sits between the control/register block (frequency word, phase clear) and downstream sample consumers (DAC formatter, modulators).

---
 rtl/sine_dds_pkg.sv | 19 +
 rtl/sine_quarter_lut.sv | 27 ++
 rtl/sine_dds.sv | 124 ++++++++++++
 tb/tb_sine_dds.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sine_dds_pkg.sv
// Shared types, default sizes and the quarter-wave ROM generator for sine_dds.
package sine_dds_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int LUT_AW_DEF  = 8;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_t;

  // Endpoints are exact: entry 0 is zero and the last entry is full scale.
  function automatic int quarter_sine_val(input int i, input int lut_aw, input int data_w);
    real amp;
    real ang;
    amp = (2.0 ** data_w) - 1.0;
    ang = (3.14159265358979 / 2.0) * $itor(i) / ((2.0 ** lut_aw) - 1.0);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Registered quarter-wave magnitude ROM; contents are fixed at elaboration.
module sine_quarter_lut
  import sine_dds_pkg::*;
#(
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic [LUT_AW-1:0] i_addr,
  output logic [DATA_W-1:0] o_mag
);

  logic [DATA_W-1:0] w_rom [2**LUT_AW];
  logic [DATA_W-1:0] r_mag;

  for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
    assign w_rom[g] = DATA_W'(quarter_sine_val(g, LUT_AW, DATA_W));
  end

  always_ff @(posedge i_clk) begin
    if (i_en) r_mag <= w_rom[i_addr];
  end

  assign o_mag = r_mag;

endmodule

// File: rtl/sine_dds.sv
// Three-stage DDS sine generator with valid/ready output and backpressure.
// Defining SINE_DDS_COS_EN adds a time-aligned o_cos_out from a second ROM.
module sine_dds
  import sine_dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int LUT_AW  = LUT_AW_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [PHASE_W-1:0]       i_freq_word,
  input  logic                     i_freq_load,
  input  logic                     i_phase_clr,
  input  logic                     i_out_ready,
  output logic                     o_out_valid,
  output logic signed [DATA_W:0]   o_sine_out
`ifdef SINE_DDS_COS_EN
  ,
  output logic signed [DATA_W:0]   o_cos_out
`endif
);

  logic [PHASE_W-1:0]  r_acc;
  logic [PHASE_W-1:0]  r_freq;
  logic [LUT_AW+1:0]   r_ph1;
  logic                r_v1, r_v2, r_v3;
  logic                r_neg2;
  logic signed [DATA_W:0] r_sine;

  logic                w_adv;
  quadrant_t           w_q;
  logic [LUT_AW-1:0]   w_a;
  logic [LUT_AW-1:0]   w_idx;
  logic                w_neg;
  logic [DATA_W-1:0]   w_mag;
  logic [DATA_W:0]     w_mag_ext;

  assign w_adv = !r_v3 || i_out_ready;

  // Only the top LUT_AW+2 phase bits matter past the accumulator.
  assign w_q   = quadrant_t'(r_ph1[LUT_AW+1:LUT_AW]);
  assign w_a   = r_ph1[LUT_AW-1:0];
  assign w_idx = (w_q == Q1 || w_q == Q3) ? ~w_a : w_a;
  assign w_neg = (w_q == Q2 || w_q == Q3);

  sine_quarter_lut #(.LUT_AW(LUT_AW), .DATA_W(DATA_W)) u_lut_sin (
    .i_clk  (i_clk),
    .i_en   (w_adv),
    .i_addr (w_idx),
    .o_mag  (w_mag)
  );

  assign w_mag_ext = {1'b0, w_mag};

`ifdef SINE_DDS_COS_EN
  quadrant_t           w_qc;
  logic [LUT_AW-1:0]   w_idx_c;
  logic                w_neg_c;
  logic [DATA_W-1:0]   w_mag_c;
  logic [DATA_W:0]     w_mag_c_ext;
  logic                r_neg2_c;
  logic signed [DATA_W:0] r_cos;

  // Cosine is the same phase advanced by one quadrant.
  assign w_qc    = quadrant_t'(r_ph1[LUT_AW+1:LUT_AW] + 2'd1);
  assign w_idx_c = (w_qc == Q1 || w_qc == Q3) ? ~w_a : w_a;
  assign w_neg_c = (w_qc == Q2 || w_qc == Q3);

  sine_quarter_lut #(.LUT_AW(LUT_AW), .DATA_W(DATA_W)) u_lut_cos (
    .i_clk  (i_clk),
    .i_en   (w_adv),
    .i_addr (w_idx_c),
    .o_mag  (w_mag_c)
  );

  assign w_mag_c_ext = {1'b0, w_mag_c};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_neg2_c <= 1'b0;
      r_cos    <= '0;
    end else if (w_adv) begin
      r_neg2_c <= w_neg_c;
      if (r_v2) r_cos <= r_neg2_c ? -w_mag_c_ext : w_mag_c_ext;
    end
  end

  assign o_cos_out = r_cos;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_freq <= '0;
      r_ph1  <= '0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_neg2 <= 1'b0;
      r_sine <= '0;
    end else begin
      if (w_adv) begin
        r_v1   <= i_en;
        r_v2   <= r_v1;
        r_v3   <= r_v2;
        r_neg2 <= w_neg;
        if (r_v2) r_sine <= r_neg2 ? -w_mag_ext : w_mag_ext;
        if (i_en) begin
          r_ph1 <= r_acc[PHASE_W-1 -: LUT_AW+2];
          r_acc <= r_acc + r_freq;
        end
      end
      // Clear wins over the advance issued in the same cycle.
      if (i_phase_clr) r_acc  <= '0;
      if (i_freq_load) r_freq <= i_freq_word;
    end
  end

  assign o_out_valid = r_v3;
  assign o_sine_out  = r_sine;

endmodule

// File: tb/tb_sine_dds.sv
// Scoreboard bench for sine_dds at PHASE_W=10, LUT_AW=8, DATA_W=8.
module tb_sine_dds;

  localparam int PW = 10;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 en;
  logic [PW-1:0]        freq_word;
  logic                 freq_load;
  logic                 phase_clr;
  logic                 out_ready;
  logic                 out_valid;
  logic signed [DW:0]   sine_out;
`ifdef SINE_DDS_COS_EN
  logic signed [DW:0]   cos_out;
`endif

  sine_dds #(.PHASE_W(PW), .LUT_AW(AW), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_freq_word (freq_word),
    .i_freq_load (freq_load),
    .i_phase_clr (phase_clr),
    .i_out_ready (out_ready),
    .o_out_valid (out_valid),
    .o_sine_out  (sine_out)
`ifdef SINE_DDS_COS_EN
    ,
    .o_cos_out   (cos_out)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int sb_sin[$];
  int sb_cos[$];

  int unsigned m_acc  = 0;
  int unsigned m_freq = 0;
  bit m_v1 = 0, m_v2 = 0, m_v3 = 0;

  int n_out      = 0;
  bit walk_mode  = 0;
  bit prev_stall = 0;
  int prev_sine  = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: quadrant decode, mirrored index, rounded quarter-sine, sign.
  function automatic int golden(input int unsigned ph, input bit cos_sel);
    int  q, a, idx, mag;
    real x;
    q = int'((ph >> (PW - 2)) & 3);
    if (cos_sel) q = (q + 1) & 3;
    a = int'((ph >> (PW - 2 - AW)) & ((1 << AW) - 1));
    idx = (q & 1) ? ((1 << AW) - 1 - a) : a;
    x = ((2.0 ** DW) - 1.0) * $sin((3.14159265358979 / 2.0) * $itor(idx) / ((2.0 ** AW) - 1.0));
    mag = $rtoi(x + 0.5);
    return (q >= 2) ? -mag : mag;
  endfunction

  task automatic spot(input int n, input int v);
    case (n)
      0:    check_val("walk_s0", v, 0);
      128:  check_val("walk_s128", v, 181);
      255:  check_val("walk_s255", v, 255);
      256:  check_val("walk_s256", v, 255);
      511:  check_val("walk_s511", v, 0);
      640:  check_val("walk_s640", v, -181);
      1023: check_val("walk_s1023", v, 0);
      1024: check_val("walk_s1024", v, 0);
      default: ;
    endcase
  endtask

  // One clock: compare outputs at the negedge, then advance the model with the edge.
  task automatic tick();
    bit adv;
    int exp;
    check_val("valid", int'(out_valid), int'(m_v3));
    if (prev_stall && out_valid) check_val("hold", int'(sine_out), prev_sine);
    if (out_valid && out_ready) begin
      if (sb_sin.size() == 0) begin
        check_val("sb_empty", sb_sin.size(), 1);
      end else begin
        exp = sb_sin.pop_front();
        check_val("sine", int'(sine_out), exp);
        if (walk_mode) spot(n_out, int'(sine_out));
        n_out++;
`ifdef SINE_DDS_COS_EN
        exp = sb_cos.pop_front();
        check_val("cos", int'(cos_out), exp);
`endif
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_sine  = int'(sine_out);
    adv = !m_v3 || out_ready;
    @(posedge clk);
    if (rst) begin
      m_acc = 0; m_freq = 0; m_v1 = 0; m_v2 = 0; m_v3 = 0;
      sb_sin.delete(); sb_cos.delete();
      prev_stall = 0;
    end else begin
      if (adv) begin
        m_v3 = m_v2; m_v2 = m_v1; m_v1 = en;
        if (en) begin
          sb_sin.push_back(golden(m_acc, 1'b0));
          sb_cos.push_back(golden(m_acc, 1'b1));
          m_acc = (m_acc + m_freq) & ((1 << PW) - 1);
        end
      end
      if (phase_clr) m_acc = 0;
      if (freq_load) m_freq = freq_word;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; freq_load = 1'b0; phase_clr = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_freq(input int unsigned w);
    freq_word = PW'(w); freq_load = 1'b1;
    tick();
    freq_load = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1; en = 1'b0; freq_word = '0; freq_load = 1'b0;
    phase_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_valid", int'(out_valid), 0);
    check_val("rst_sine", int'(sine_out), 0);
    rst = 1'b0;

    // Full-cycle walk at one LSB per sample
    load_freq(1);
    en = 1'b1;
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check_val("latency", lat, 3);
    walk_mode = 1'b1;
    n_out = 0;
    repeat (1030) tick();
    walk_mode = 1'b0;
    check_val("walk_count", int'(n_out >= 1025), 1);

    // Backpressure mid-stream
    do_reset();
    load_freq(64);
    en = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    repeat (8) tick();

    // Enable gaps
    en = 1'b1; tick();
    en = 1'b0; tick(); tick();
    en = 1'b1; repeat (6) tick();

    // Simultaneous phase clear and frequency change
    freq_word = PW'(256); freq_load = 1'b1; phase_clr = 1'b1;
    tick();
    freq_load = 1'b0; phase_clr = 1'b0;
    repeat (8) tick();

    // Zero frequency word holds the current phase
    load_freq(0);
    repeat (6) tick();

    // Random enable and backpressure
    load_freq(37);
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    out_ready = 1'b1; en = 1'b1;
    repeat (4) tick();

    // Reset while stalled with a valid sample pending
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("stall_rst_valid", int'(out_valid), 0);
    check_val("stall_rst_sine", int'(sine_out), 0);
    out_ready = 1'b1; en = 1'b0;
    repeat (4) tick();

    en = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    check_val("sb_drained", sb_sin.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
